// File: rtl/arc4_ctrl.sv
// arc4_ctrl: sequencer for one ARC4 decrypt pass.
// Runs init -> ksa -> prga with the rdy/en handshake on each sub-block and
// arbitrates the shared single-port S RAM so only the active sub-block drives it.
// Optional build macro ARC4_CTRL_CYCLE_CNT_EN adds a saturating busy-cycle
// counter on output cycles[31:0].
module arc4_ctrl #(
  parameter int KEY_W       = 24,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             rdy,
  input  logic             en,
  input  logic [KEY_W-1:0] key,
  output logic             err,
  input  logic             init_rdy,
  input  logic             ksa_rdy,
  input  logic             prga_rdy,
  output logic             init_en,
  output logic             ksa_en,
  output logic             prga_en,
  output logic [KEY_W-1:0] ksa_key,
  input  logic [7:0]       init_s_addr,
  input  logic [7:0]       ksa_s_addr,
  input  logic [7:0]       prga_s_addr,
  input  logic [7:0]       init_s_din,
  input  logic [7:0]       ksa_s_din,
  input  logic [7:0]       prga_s_din,
  input  logic             init_s_wren,
  input  logic             ksa_s_wren,
  input  logic             prga_s_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_din,
`ifdef ARC4_CTRL_CYCLE_CNT_EN
  output logic             s_wren,
  output logic [31:0]      cycles
`else
  output logic             s_wren
`endif
);

  // Counter covers 0..ACK_TIMEOUT so the width is safe for any timeout >= 1.
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT_GO  = 4'd1,
    S_INIT_ACK = 4'd2,
    S_INIT_RUN = 4'd3,
    S_KSA_GO   = 4'd4,
    S_KSA_ACK  = 4'd5,
    S_KSA_RUN  = 4'd6,
    S_PRGA_GO  = 4'd7,
    S_PRGA_ACK = 4'd8,
    S_PRGA_RUN = 4'd9,
    S_DONE     = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_INIT = 2'd1,
    G_KSA  = 2'd2,
    G_PRGA = 2'd3
  } grant_t;

  state_t           state, state_nxt;
  grant_t           grant, grant_nxt;
  logic [ACK_W-1:0] ack_cnt, ack_cnt_nxt;
  logic [KEY_W-1:0] key_q, key_nxt;
  logic             err_q, err_nxt;
  logic             rdy_q, rdy_nxt;
  logic             init_en_q, init_en_nxt;
  logic             ksa_en_q, ksa_en_nxt;
  logic             prga_en_q, prga_en_nxt;
  logic             sel_rdy;

  // Pick the ready line of the sub-block that owns the current phase.
  always_comb begin
    sel_rdy = 1'b0;
    case (state)
      S_INIT_GO, S_INIT_ACK, S_INIT_RUN: sel_rdy = init_rdy;
      S_KSA_GO,  S_KSA_ACK,  S_KSA_RUN:  sel_rdy = ksa_rdy;
      S_PRGA_GO, S_PRGA_ACK, S_PRGA_RUN: sel_rdy = prga_rdy;
      default:                           sel_rdy = 1'b0;
    endcase
  end

  // Next-state, start pulses, ack timeout and key/err updates.
  always_comb begin
    state_nxt   = state;
    ack_cnt_nxt = ack_cnt;
    key_nxt     = key_q;
    err_nxt     = err_q;
    init_en_nxt = 1'b0;
    ksa_en_nxt  = 1'b0;
    prga_en_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          key_nxt   = key;
          err_nxt   = 1'b0;
          state_nxt = S_INIT_GO;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_INIT_GO, S_KSA_GO, S_PRGA_GO: begin
        ack_cnt_nxt = {ACK_W{1'b0}};
        if (sel_rdy) begin
          if (state == S_INIT_GO) begin
            init_en_nxt = 1'b1;
            state_nxt   = S_INIT_ACK;
          end else if (state == S_KSA_GO) begin
            ksa_en_nxt  = 1'b1;
            state_nxt   = S_KSA_ACK;
          end else begin
            prga_en_nxt = 1'b1;
            state_nxt   = S_PRGA_ACK;
          end
        end else begin
          state_nxt = state;
        end
      end
      S_INIT_ACK, S_KSA_ACK, S_PRGA_ACK: begin
        if (!sel_rdy) begin
          if (state == S_INIT_ACK) begin
            state_nxt = S_INIT_RUN;
          end else if (state == S_KSA_ACK) begin
            state_nxt = S_KSA_RUN;
          end else begin
            state_nxt = S_PRGA_RUN;
          end
        end else if (ack_cnt == ACK_LAST) begin
          // Sub-block never acknowledged its start pulse: abort the pass.
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          ack_cnt_nxt = ack_cnt + {{(ACK_W-1){1'b0}}, 1'b1};
        end
      end
      S_INIT_RUN: begin
        if (init_rdy) begin
          state_nxt = S_KSA_GO;
        end else begin
          state_nxt = S_INIT_RUN;
        end
      end
      S_KSA_RUN: begin
        if (ksa_rdy) begin
          state_nxt = S_PRGA_GO;
        end else begin
          state_nxt = S_KSA_RUN;
        end
      end
      S_PRGA_RUN: begin
        if (prga_rdy) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_PRGA_RUN;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant and ready follow the state being entered so both are registered.
  always_comb begin
    grant_nxt = G_NONE;
    case (state_nxt)
      S_INIT_GO, S_INIT_ACK, S_INIT_RUN: grant_nxt = G_INIT;
      S_KSA_GO,  S_KSA_ACK,  S_KSA_RUN:  grant_nxt = G_KSA;
      S_PRGA_GO, S_PRGA_ACK, S_PRGA_RUN: grant_nxt = G_PRGA;
      default:                           grant_nxt = G_NONE;
    endcase
    rdy_nxt = (state_nxt == S_IDLE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= G_NONE;
      ack_cnt   <= {ACK_W{1'b0}};
      key_q     <= {KEY_W{1'b0}};
      err_q     <= 1'b0;
      rdy_q     <= 1'b1;
      init_en_q <= 1'b0;
      ksa_en_q  <= 1'b0;
      prga_en_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      ack_cnt   <= ack_cnt_nxt;
      key_q     <= key_nxt;
      err_q     <= err_nxt;
      rdy_q     <= rdy_nxt;
      init_en_q <= init_en_nxt;
      ksa_en_q  <= ksa_en_nxt;
      prga_en_q <= prga_en_nxt;
    end
  end

  // S RAM port goes to the granted requester only; idle grant drives zeros.
  always_comb begin
    s_addr = 8'h00;
    s_din  = 8'h00;
    s_wren = 1'b0;
    case (grant)
      G_INIT: begin
        s_addr = init_s_addr;
        s_din  = init_s_din;
        s_wren = init_s_wren;
      end
      G_KSA: begin
        s_addr = ksa_s_addr;
        s_din  = ksa_s_din;
        s_wren = ksa_s_wren;
      end
      G_PRGA: begin
        s_addr = prga_s_addr;
        s_din  = prga_s_din;
        s_wren = prga_s_wren;
      end
      default: begin
        s_addr = 8'h00;
        s_din  = 8'h00;
        s_wren = 1'b0;
      end
    endcase
  end

`ifdef ARC4_CTRL_CYCLE_CNT_EN
  logic [31:0] cycles_q;

  // Busy-cycle counter: restarts on accept, counts while busy, saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycles_q <= 32'h0000_0000;
    end else if (state == S_IDLE && en) begin
      cycles_q <= 32'h0000_0000;
    end else if (!rdy_q && cycles_q != 32'hFFFF_FFFF) begin
      cycles_q <= cycles_q + 32'h0000_0001;
    end else begin
      cycles_q <= cycles_q;
    end
  end

  assign cycles = cycles_q;
`endif

  assign rdy     = rdy_q;
  assign err     = err_q;
  assign init_en = init_en_q;
  assign ksa_en  = ksa_en_q;
  assign prga_en = prga_en_q;
  assign ksa_key = key_q;

endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl: randomized self-checking bench for arc4_ctrl with
// behavioural sub-block models and a pass-level reference of the expected
// start-pulse order, error timing, S RAM ownership and busy-cycle count.
module tb_arc4_ctrl;
  localparam int KEY_W = 24;
  localparam int ACK_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [KEY_W-1:0] key = '0;
  logic rdy, err, init_en, ksa_en, prga_en, s_wren;
  logic [KEY_W-1:0] ksa_key;
  logic [7:0] s_addr, s_din;
  logic [31:0] cycles;

  // sub-block models: index 0 init, 1 ksa, 2 prga
  logic [2:0] m_rdy;
  int m_cnt[3];
  int m_len[3];
  bit m_stuck[3];
  logic [7:0] r_addr[3];
  logic [7:0] r_din[3];
  logic r_wren[3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ksa_cyc = -1;
  int err_cyc = -1;
  bit mon_on = 1'b0;
  int en_log[$];

  always #5 clk = ~clk;

  arc4_ctrl #(.KEY_W(KEY_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .en(en), .key(key), .err(err),
    .init_rdy(m_rdy[0]), .ksa_rdy(m_rdy[1]), .prga_rdy(m_rdy[2]),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en), .ksa_key(ksa_key),
    .init_s_addr(r_addr[0]), .ksa_s_addr(r_addr[1]), .prga_s_addr(r_addr[2]),
    .init_s_din(r_din[0]), .ksa_s_din(r_din[1]), .prga_s_din(r_din[2]),
    .init_s_wren(r_wren[0]), .ksa_s_wren(r_wren[1]), .prga_s_wren(r_wren[2]),
    .s_addr(s_addr), .s_din(s_din),
`ifdef ARC4_CTRL_CYCLE_CNT_EN
    .s_wren(s_wren), .cycles(cycles)
`else
    .s_wren(s_wren)
`endif
  );
`ifndef ARC4_CTRL_CYCLE_CNT_EN
  assign cycles = 32'h0000_0000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sub-block model: accepts en while ready, then stays busy for m_len cycles.
  always @(posedge clk) begin
    logic [2:0] ens;
    ens = {prga_en, ksa_en, init_en};
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_rdy[i] <= 1'b1;
        m_cnt[i] <= 0;
      end else if (m_rdy[i] && ens[i] && !m_stuck[i]) begin
        m_rdy[i] <= 1'b0;
        m_cnt[i] <= m_len[i];
      end else if (!m_rdy[i]) begin
        if (m_cnt[i] == 1) m_rdy[i] <= 1'b1;
        m_cnt[i] <= m_cnt[i] - 1;
      end
    end
  end

  // Random requester traffic, pulse logging and S RAM ownership checks.
  always @(negedge clk) begin
    logic [2:0] ens;
    for (int i = 0; i < 3; i++) begin
      r_addr[i] = 8'($urandom);
      r_din[i]  = 8'($urandom);
      r_wren[i] = 1'($urandom);
    end
    #1;
    cyc++;
    if (mon_on) begin
      ens = {prga_en, ksa_en, init_en};
      if (ens != 3'b000) begin
        check("en_onehot", 32'($countones(ens)), 32'd1);
        for (int i = 0; i < 3; i++) if (ens[i]) en_log.push_back(i);
        if (ksa_en && ksa_cyc < 0) ksa_cyc = cyc;
      end
      if (err && err_cyc < 0) err_cyc = cyc;
      for (int i = 0; i < 3; i++) begin
        if (!m_rdy[i]) begin
          check("mux_addr", {24'd0, s_addr}, {24'd0, r_addr[i]});
          check("mux_din",  {24'd0, s_din},  {24'd0, r_din[i]});
          check("mux_wren", {31'd0, s_wren}, {31'd0, r_wren[i]});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    check({tag, "_ens"}, {29'd0, prga_en, ksa_en, init_en}, 32'd0);
    check({tag, "_wren"}, {31'd0, s_wren}, 32'd0);
    check({tag, "_addr"}, {24'd0, s_addr}, 32'd0);
  endtask

  // One full pass; the reference is the pass-level outcome from the rules.
  task automatic run_pass(input logic [KEY_W-1:0] k, input int l0, input int l1,
                          input int l2, input bit stuck, input bit poke);
    int n;
    bit poked;
    int exp_n;
    logic [31:0] exp_cyc;
    m_len[0] = l0; m_len[1] = l1; m_len[2] = l2;
    m_stuck[1] = stuck;
    n = 0;
    while (!rdy && n < 100) begin step(); n++; end
    check("pre_rdy", {31'd0, rdy}, 32'd1);
    en = 1'b1; key = k;
    en_log.delete(); ksa_cyc = -1; err_cyc = -1;
    step();
    en = 1'b0; key = KEY_W'($urandom);
    check("accept_rdy", {31'd0, rdy}, 32'd0);
    check("accept_err", {31'd0, err}, 32'd0);
    n = 0; poked = 1'b0;
    while (!rdy && n < 5000) begin
      en = 1'b0;
      if (poke && !poked && !m_rdy[2]) begin en = 1'b1; poked = 1'b1; end
      step();
      n++;
    end
    en = 1'b0;
    check("pass_done", {31'd0, rdy}, 32'd1);
    exp_n = stuck ? 2 : 3;
    check("en_count", 32'(en_log.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < en_log.size(); i++)
      check("en_order", 32'(en_log[i]), 32'(i));
    check("ksa_key", 32'(ksa_key), 32'(k));
    check("err", {31'd0, err}, {31'd0, stuck});
    if (stuck) check("err_delay", 32'(err_cyc - ksa_cyc), 32'(ACK_TIMEOUT));
`ifdef ARC4_CTRL_CYCLE_CNT_EN
    if (!stuck) begin
      exp_cyc = 32'(l0 + l1 + l2 + 3 * 3 + 1);
      check("cycles", cycles, exp_cyc);
      for (int i = 0; i < 5; i++) step();
      check("cycles_hold", cycles, exp_cyc);
    end
`else
    exp_cyc = 32'd0;
`endif
    for (int i = 0; i < 3; i++) step();
    check("post_pulses", 32'(en_log.size()), 32'(exp_n));
    check_idle("post");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin m_len[i] = 1; m_stuck[i] = 1'b0; end
    mon_on = 1'b1;
    // reset held with en high must not start a pass
    rst_n = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_idle("rst");
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_key", 32'(ksa_key), 32'd0);
    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rst_nostart", 32'(en_log.size()), 32'd0);
    check_idle("rel");

    run_pass(24'h00033C, 1, 1, 1, 1'b0, 1'b0);
    run_pass(KEY_W'($urandom), 12, 20, 9, 1'b0, 1'b1);
    run_pass(KEY_W'($urandom), 3, 5, 5, 1'b1, 1'b0);
    run_pass(KEY_W'($urandom), 7, 4, 11, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++)
      run_pass(KEY_W'($urandom), $urandom_range(1, 30), $urandom_range(1, 30),
               $urandom_range(1, 30), 1'b0, 1'($urandom));
    run_pass(KEY_W'($urandom), 256, 768, 600, 1'b0, 1'b0);

    // reset in the middle of the ksa run
    m_len[0] = 4; m_len[1] = 60; m_len[2] = 4; m_stuck[1] = 1'b0;
    en = 1'b1; key = KEY_W'($urandom);
    step();
    en = 1'b0;
    begin
      int n;
      n = 0;
      while (m_rdy[1] && n < 200) begin step(); n++; end
      check("ksa_busy", {31'd0, m_rdy[1]}, 32'd0);
    end
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    check_idle("midrst");
    check("midrst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    en_log.delete();
    for (int i = 0; i < 10; i++) step();
    check("midrst_quiet", 32'(en_log.size()), 32'd0);
    run_pass(KEY_W'($urandom), 6, 8, 10, 1'b0, 1'b0);

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
